expu_stream: RTL and testbench
==============================

Name: expu_stream

Overview:
- Multi-lane, pipelined Schraudolph exponential unit: computes e^x per lane for NUM_LANES packed IEEE-style floats using a valid/ready stream handshake.
- Successor to the single-lane, enable-driven exp unit. Adds lane count, configurable pipeline depth, backpressure with bubble collapse, a synchronous flush, and explicit special-value handling.
- Sits between a vector register/stream source and the softmax accumulation datapath.

Parameters:
- MANTISSA_BITS, 7: input/output mantissa width M.
- EXPONENT_BITS, 8: exponent width E; bias B = 2^(E-1)-1.
- A_FRACTION, 2*MANTISSA_BITS: fraction bits of constant LOG2E = round(log2(e)*2^A_FRACTION); 23637 for the default.
- ENABLE_ROUNDING, 1: 1 = round-half-up of |y| to M fraction bits; 0 = truncate.
- NUM_LANES, 4: independent lanes sharing one handshake.
- PIPE_STAGES, 2: register stages, legal range 1..4; latency equals PIPE_STAGES cycles.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- clear_i  in  1  synchronous flush of all stages
- in_valid_i  in  1  input vector valid
- in_ready_o  out  1  input vector accepted when valid and ready are both high
- in_data_i  in  NUM_LANES*(M+E+1)  lane k occupies bits [k*(M+E+1) +: M+E+1]
- out_valid_o  out  1  output vector valid
- out_ready_i  in  1  downstream ready
- out_data_o  out  NUM_LANES*(M+E+1)  results, same packing as the input
- busy_o  out  1  at least one stage holds valid data

Behaviour:
- Reset: all stage valid bits are cleared and all data registers are zeroed.
  - out_valid_o=0, out_data_o=0, busy_o=0, in_ready_o=1 immediately on assertion and while rst_i is high.
  - Reset mid-operation discards all in-flight data.
- clear_i: zeroes all valid bits on the next edge and has priority over any concurrent accept. in_ready_o is 0 while clear_i is high.
- Pipeline:
  - Each stage s carries a valid bit v[s].
  - Stage s loads when v[s]=0 or stage s is advancing. The last stage advances when out_ready_i=1.
  - in_ready_o = stage-0 load condition (combinational from out_ready_i and the valid bits).
  - Bubbles collapse.
  - A full pipeline with out_ready_i=1 sustains 1 vector per cycle.
  - When out_ready_i=0 and all stages are valid: in_ready_o=0, and out_data_o is held stable.
- Latency: a vector accepted at edge t appears with out_valid_o=1 after edge t+PIPE_STAGES-1, provided there is no stall.
- Per-lane arithmetic. Input fields are s, e, m.
  - Saturation by input exponent:
    - e-B >= E+1: +inf if s=0, +0 if s=1.
    - e-B < -(M+A_FRACTION), or e=0 (denormals are treated as zero): result is 1.0 (exp=B, mant=0).
  - Otherwise:
    - |y| = (1.m * 2^(e-B)) * LOG2E, reduced to M fraction bits per ENABLE_ROUNDING, computed on the magnitude.
    - y = -|y| if s=1, in two's complement with E+2 integer bits.
  - Result:
    - exp_r = floor(y)+B, mant_r = the M fraction bits of y, sign 0.
    - exp_r >= 2^E-1 produces +inf.
    - exp_r <= 0 produces +0; no denormal output.
- Special inputs:
  - NaN (e all ones, m≠0) produces canonical NaN: sign 0, exp all ones, mant MSB 1, other bits 0.
  - +inf produces +inf.
  - -inf produces +0.
- Lanes are fully independent; a special value in one lane does not affect other lanes.
- Stage partitioning is implementation choice, but results must be identical for every PIPE_STAGES value.

Test Plan:
- Defaults, lanes = {0x3F80, 0x0000, 0xBF80, 0x42C8}, out_ready_i=1 → after 2 cycles out lanes = {0x4039, 0x3F80, 0x3EC7, 0x7F80}.
- ENABLE_ROUNDING=0, lanes = {0x3F80, 0xBF80, 0xC2C8, 0x0001} → {0x4038, 0x3EC8, 0x0000, 0x3F80}.
- Special values: lanes = {0x7FC1, 0x7F80, 0xFF80, 0x4400} (x=512) → {0x7FC0, 0x7F80, 0x0000, 0x7F80}.
- Backpressure: stream 8 vectors, out_ready_i=0 for cycles 3-7 → in_ready_o drops once both stages are full, out_data_o is held stable, and all 8 results appear in order with none lost or duplicated. A random-ready soak across PIPE_STAGES=1..4 must match the reference model.
- Bubble collapse: valid, gap, valid with out_ready_i=0 → both vectors occupy adjacent stages and in_ready_o=0 after the second accept.
- Flush and reset: clear_i asserted with in_valid_i=1 and 2 vectors in flight → next cycle busy_o=0 and out_valid_o=0 with no accept. Assert rst_i asynchronously between edges → outputs go to 0 immediately and in_ready_o=1.

Source files
------------

// File: rtl/expu_stream.sv
// ---------------------------------------------------------------------------
// expu_stream
//   Multi-lane pipelined Schraudolph exponential unit. Each lane computes
//   e^x by scaling x with log2(e) in fixed point and reinterpreting the
//   result y as (integer part -> exponent, fraction -> mantissa).
//   All lanes share one valid/ready handshake; the pipeline collapses
//   bubbles and holds its output under backpressure.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous active-high reset (clears valid + data)
//   clear_i      synchronous flush of every stage, beats a concurrent accept
//   in_valid_i   input vector valid
//   in_ready_o   input accepted when in_valid_i && in_ready_o
//   in_data_i    NUM_LANES packed floats, lane k at [k*LW +: LW]
//   out_valid_o  output vector valid
//   out_ready_i  downstream ready
//   out_data_o   NUM_LANES results, same packing as the input
//   busy_o       some stage holds valid data
// ---------------------------------------------------------------------------
module expu_stream #(
  parameter int MANTISSA_BITS   = 7,
  parameter int EXPONENT_BITS   = 8,
  parameter int A_FRACTION      = 2*MANTISSA_BITS,
  parameter int ENABLE_ROUNDING = 1,
  parameter int NUM_LANES       = 4,
  parameter int PIPE_STAGES     = 2
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_i,
  input  logic                                                   clear_i,
  input  logic                                                   in_valid_i,
  output logic                                                   in_ready_o,
  input  logic [NUM_LANES*(MANTISSA_BITS+EXPONENT_BITS+1)-1:0]   in_data_i,
  output logic                                                   out_valid_o,
  input  logic                                                   out_ready_i,
  output logic [NUM_LANES*(MANTISSA_BITS+EXPONENT_BITS+1)-1:0]   out_data_o,
  output logic                                                   busy_o
);

  localparam int M    = MANTISSA_BITS;
  localparam int E    = EXPONENT_BITS;
  localparam int A    = A_FRACTION;
  localparam int LW   = M + E + 1;
  localparam int BIAS = (2 ** (E - 1)) - 1;

  // Product {1.m} * LOG2E, then headroom so the left-shift path (only
  // reachable for A < E) cannot lose integer bits.
  localparam int PW = (M + 1) + (A + 1);
  localparam int YW = PW + E + 2;

  // Intermediate lane record carried between stages: {class, sign, |y|}.
  localparam int IW = YW + 3;

  localparam real LOG2E_REAL = 1.4426950408889634;
  localparam int  LOG2E_INT  = $rtoi(LOG2E_REAL * (2.0 ** A) + 0.5);
  localparam logic [YW-1:0] LOG2E_V = YW'(LOG2E_INT);

  // Result class. ZERO is encoding 0 so a zeroed data register decodes to +0.
  localparam logic [1:0] CLS_ZERO = 2'd0;
  localparam logic [1:0] CLS_INF  = 2'd1;
  localparam logic [1:0] CLS_NAN  = 2'd2;
  localparam logic [1:0] CLS_FIN  = 2'd3;

  localparam logic [LW-1:0] INF_VAL = {1'b0, {E{1'b1}}, {M{1'b0}}};
  localparam logic [LW-1:0] NAN_VAL = INF_VAL | (LW'(1) << (M - 1));

  localparam logic signed [YW+1:0] BIAS_S    = (YW+2)'(BIAS);
  localparam logic signed [YW+1:0] EXP_MAX_S = (YW+2)'((2 ** E) - 1);
  localparam logic signed [YW+1:0] ZERO_S    = '0;

  // -------------------------------------------------------------------------
  // Front half: classify the input and form the rounded magnitude |y| with
  // M fraction bits. Saturating inputs fold into ZERO/INF; underflowing and
  // denormal inputs become a finite y = 0, which decodes to exactly 1.0.
  // -------------------------------------------------------------------------
  function automatic logic [IW-1:0] lane_front(input logic [LW-1:0] x);
    logic          s;
    logic [E-1:0]  e;
    logic [M-1:0]  m;
    int            unb;
    int            sh;
    logic [YW-1:0] p;
    logic [YW-1:0] mag;
    logic [1:0]    cls;
    logic          sgn;
    s   = x[LW-1];
    e   = x[M +: E];
    m   = x[M-1:0];
    unb = int'(e) - BIAS;
    cls = CLS_FIN;
    sgn = 1'b0;
    mag = '0;
    p   = '0;
    sh  = 0;
    if ((&e) && (|m)) begin
      cls = CLS_NAN;
    end else if (unb >= E + 1) begin
      // Also covers +/-inf: e^+inf = +inf, e^-inf = +0.
      cls = s ? CLS_ZERO : CLS_INF;
    end else if ((e == '0) || (unb < -(M + A))) begin
      cls = CLS_FIN;
    end else begin
      p  = YW'({1'b1, m}) * LOG2E_V;
      // p carries M+A fraction bits; aligning to M fraction bits and
      // applying 2^unb is one net shift by (unb - A).
      sh = unb - A;
      if (sh >= 0) begin
        mag = p << sh;
      end else begin
        if (ENABLE_ROUNDING != 0) begin
          p = p + (YW'(1) << (-sh - 1));
        end
        mag = p >> (-sh);
      end
      sgn = s;
    end
    return {cls, sgn, mag};
  endfunction

  // -------------------------------------------------------------------------
  // Back half: apply the sign in two's complement, split y into floor and
  // fraction, add the bias and saturate to +inf / +0.
  // -------------------------------------------------------------------------
  function automatic logic [LW-1:0] lane_back(input logic [IW-1:0] r);
    logic [1:0]             cls;
    logic                   sgn;
    logic [YW-1:0]          mag;
    logic signed [YW+1:0]   y;
    logic signed [YW+1:0]   er;
    logic [LW-1:0]          res;
    {cls, sgn, mag} = r;
    y   = sgn ? -$signed({2'b00, mag}) : $signed({2'b00, mag});
    // Arithmetic shift is floor() for negative y as well.
    er  = (y >>> M) + BIAS_S;
    res = '0;
    case (cls)
      CLS_NAN: res = NAN_VAL;
      CLS_INF: res = INF_VAL;
      CLS_FIN: begin
        if (er >= EXP_MAX_S) begin
          res = INF_VAL;
        end else if (er <= ZERO_S) begin
          res = '0;
        end else begin
          res = {1'b0, er[E-1:0], y[M-1:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  logic [NUM_LANES*IW-1:0] front_d;
  logic [NUM_LANES*IW-1:0] dat_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0]  vld_q;
  logic [PIPE_STAGES-1:0]  load;
  logic [PIPE_STAGES-1:0]  adv;

  always_comb begin
    front_d = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      front_d[k*IW +: IW] = lane_front(in_data_i[k*LW +: LW]);
    end
  end

  // Load/advance chain, resolved from the output backwards: a stage loads
  // when it is empty or its content moves on this edge, which is what
  // collapses bubbles.
  always_comb begin
    logic nxt;
    load = '0;
    adv  = '0;
    nxt  = out_ready_i;
    for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
      adv[s]  = vld_q[s] & nxt;
      load[s] = ~vld_q[s] | adv[s];
      nxt     = load[s];
    end
  end

  assign in_ready_o  = load[0] & ~clear_i;
  assign out_valid_o = vld_q[PIPE_STAGES-1];
  assign busy_o      = |vld_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        dat_q[s] <= '0;
      end
    end else if (clear_i) begin
      vld_q <= '0;
    end else begin
      // ---- stage 0: capture classified magnitude of the input vector ----
      if (load[0]) begin
        vld_q[0] <= in_valid_i;
        if (in_valid_i) begin
          dat_q[0] <= front_d;
        end
      end
      // ---- stages 1..N-1: move records forward ----
      for (int s = 1; s < PIPE_STAGES; s++) begin
        if (load[s]) begin
          vld_q[s] <= vld_q[s-1];
          if (vld_q[s-1]) begin
            dat_q[s] <= dat_q[s-1];
          end
        end
      end
    end
  end

  // ---- output: finish the lane arithmetic on the last stage ----
  always_comb begin
    out_data_o = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      out_data_o[k*LW +: LW] = lane_back(dat_q[PIPE_STAGES-1][k*IW +: IW]);
    end
  end

endmodule

// File: tb/tb_expu_stream.sv
module tb_expu_stream;

  localparam int NI = 5;  // instances 0..3: PIPE_STAGES 1..4, instance 4: truncating, 2 stages

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] in_data;
  logic [NI-1:0] ov, ir, bz;
  logic [63:0] od [NI];

  int n_tests = 0;
  int n_fail  = 0;
  int popcnt [NI];

  typedef struct packed {
    logic [2:0]  inst;
    logic [63:0] val;
  } sb_t;
  sb_t sbq [$];

  typedef struct {
    logic [63:0] din;
    logic [63:0] exp_r;
    logic [63:0] exp_t;
  } vec_t;
  vec_t tbl [7];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_depth
    expu_stream #(.PIPE_STAGES(g + 1)) u_dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear),
      .in_valid_i(in_valid), .in_ready_o(ir[g]), .in_data_i(in_data),
      .out_valid_o(ov[g]), .out_ready_i(out_ready), .out_data_o(od[g]),
      .busy_o(bz[g]));
  end

  expu_stream #(.ENABLE_ROUNDING(0)) u_dut_trunc (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(ir[4]), .in_data_i(in_data),
    .out_valid_o(ov[4]), .out_ready_i(out_ready), .out_data_o(od[4]),
    .busy_o(bz[4]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: integer division on the exact product, independent of shifts.
  function automatic logic [15:0] ref_lane(input logic [15:0] x, input bit rnd);
    int     e, m, ub, r;
    longint p, den, mag, y, fl, fr, er;
    bit     s;
    s = x[15];
    e = int'(x[14:7]);
    m = int'(x[6:0]);
    if (e == 255 && m != 0) return 16'h7FC0;
    ub = e - 127;
    if (ub >= 9) return s ? 16'h0000 : 16'h7F80;
    if (e == 0 || ub < -21) return 16'h3F80;
    p   = longint'(128 + m) * 64'sd23637;
    r   = 14 - ub;
    den = longint'(1) << r;
    mag = rnd ? (p + den / 2) / den : p / den;
    y   = s ? -mag : mag;
    fl  = (y >= 0) ? y / 128 : -((-y + 127) / 128);
    fr  = y - fl * 128;
    er  = fl + 127;
    if (er >= 255) return 16'h7F80;
    if (er <= 0) return 16'h0000;
    return {1'b0, er[7:0], fr[6:0]};
  endfunction

  function automatic logic [63:0] ref_vec(input logic [63:0] x, input bit rnd);
    logic [63:0] r;
    for (int l = 0; l < 4; l++) r[l*16 +: 16] = ref_lane(x[l*16 +: 16], rnd);
    return r;
  endfunction

  function automatic logic [15:0] rand_lane();
    logic [15:0] v;
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) begin
      v = 16'($urandom);
    end else if (sel == 1) begin
      case ($urandom_range(0, 3))
        0: v = 16'h7F80;
        1: v = 16'hFF80;
        2: v = 16'h7FC1;
        default: v = 16'h0001;
      endcase
    end else begin
      v = {1'($urandom), 8'($urandom_range(100, 137)), 7'($urandom)};
    end
    return v;
  endfunction

  function automatic logic [63:0] rand_vec();
    return {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
  endfunction

  // Scoreboard: push model result on accept, pop and compare on output transfer.
  always @(negedge clk) begin
    int idx;
    if (rst || clear) begin
      sbq.delete();
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (ov[k] && out_ready) begin
          idx = -1;
          for (int j = 0; j < sbq.size(); j++) begin
            if (sbq[j].inst == 3'(k)) begin
              idx = j;
              break;
            end
          end
          if (idx < 0) begin
            check($sformatf("sb_unexpected_%0d", k), 64'(ov[k]), 64'd0);
          end else begin
            check($sformatf("sb_data_%0d", k), od[k], sbq[idx].val);
            sbq.delete(idx);
          end
          popcnt[k]++;
        end
        if (in_valid && ir[k]) sbq.push_back('{3'(k), ref_vec(in_data, k != 4)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] bp [8];
    logic [63:0] prev, va, vb;
    int i, c, p0, pend;
    bit acc;

    tbl[0] = '{64'h3F80_0000_BF80_42C8, 64'h4039_3F80_3EC7_7F80, 64'h4038_3F80_3EC8_7F80};
    tbl[1] = '{64'h3F80_BF80_C2C8_0001, 64'h4039_3EC7_0000_3F80, 64'h4038_3EC8_0000_3F80};
    tbl[2] = '{64'h7FC1_7F80_FF80_4400, 64'h7FC0_7F80_0000_7F80, 64'h7FC0_7F80_0000_7F80};
    tbl[3] = '{64'h4000_C000_3F00_42B0, 64'h40F1_3E0F_3FDC_7EFA, 64'h40F1_3E0F_3FDC_7EFA};
    tbl[4] = '{64'h42B2_C2B2_C2AE_C2B0, 64'h7F80_0000_00BE_0000, 64'h7F80_0000_00BF_0000};
    tbl[5] = '{64'h3400_3500_FFFF_4380, 64'h3F80_3F80_7FC0_7F80, 64'h3F80_3F80_7FC0_7F80};
    tbl[6] = '{64'h3C00_BC00_3B80_BB80, 64'h3F81_3F7F_3F81_3F7F, 64'h3F81_3F7F_3F80_3F80};

    for (int k = 0; k < NI; k++) popcnt[k] = 0;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;

    // Reset state
    #3;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_out_valid_%0d", k), 64'(ov[k]), 64'd0);
      check($sformatf("rst_out_data_%0d", k), od[k], 64'd0);
      check($sformatf("rst_busy_%0d", k), 64'(bz[k]), 64'd0);
      check($sformatf("rst_in_ready_%0d", k), 64'(ir[k]), 64'd1);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Directed vectors, 2-cycle latency on the 2-stage instances
    for (int t = 0; t < 7; t++) begin
      in_data = tbl[t].din;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check($sformatf("vec%0d_valid", t), 64'(ov[1]), 64'd1);
      check($sformatf("vec%0d_round", t), od[1], tbl[t].exp_r);
      check($sformatf("vec%0d_trunc", t), od[4], tbl[t].exp_t);
    end
    repeat (6) tick();

    // Backpressure: 8 vectors, out_ready low in cycles 3..7
    for (int k = 0; k < 8; k++) bp[k] = rand_vec();
    i = 0; c = 0; p0 = popcnt[1]; prev = '0;
    while ((popcnt[1] - p0 < 8) && (c < 60)) begin
      out_ready = !(c >= 3 && c <= 7);
      in_valid  = (i < 8);
      in_data   = (i < 8) ? bp[i] : 64'd0;
      @(negedge clk);
      if (c >= 3 && c <= 7) begin
        check($sformatf("bp_in_ready_c%0d", c), 64'(ir[1]), 64'd0);
        if (c > 3) check($sformatf("bp_hold_c%0d", c), od[1], prev);
      end
      prev = od[1];
      acc = in_valid && ir[1];
      tick();
      if (acc) i++;
      c++;
    end
    check("bp_outputs", 64'(popcnt[1] - p0), 64'd8);
    check("bp_accepts", 64'(i), 64'd8);
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (6) tick();

    // Bubble collapse: valid, gap, valid with the output stalled
    va = 64'h3F80_4000_C000_3C00;
    vb = 64'hBF80_3F00_42B0_BC00;
    out_ready = 1'b0;
    in_data = va; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_data = vb; in_valid = 1'b1;
    @(negedge clk);
    check("bub_accept_b", 64'(ir[1]), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bub_in_ready", 64'(ir[1]), 64'd0);
    check("bub_busy", 64'(bz[1]), 64'd1);
    check("bub_out_a", od[1], ref_vec(va, 1'b1));
    out_ready = 1'b1;
    @(negedge clk);
    check("bub_first_valid", 64'(ov[1]), 64'd1);
    tick();
    check("bub_second_valid", 64'(ov[1]), 64'd1);
    check("bub_out_b", od[1], ref_vec(vb, 1'b1));
    tick();
    check("bub_empty", 64'(ov[1]), 64'd0);
    repeat (4) tick();

    // Flush with two vectors in flight and a concurrent valid input
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = rand_vec();
    tick();
    in_data = rand_vec();
    tick();
    clear = 1'b1; in_data = rand_vec();
    @(negedge clk);
    check("clr_in_ready", 64'(ir[1]), 64'd0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("clr_busy_%0d", k), 64'(bz[k]), 64'd0);
      check($sformatf("clr_valid_%0d", k), 64'(ov[k]), 64'd0);
    end
    repeat (3) tick();
    check("clr_no_accept", 64'(ov[1]), 64'd0);

    // Asynchronous reset between edges with data in flight
    in_valid = 1'b1; in_data = rand_vec();
    tick();
    in_data = rand_vec();
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("arst_valid_%0d", k), 64'(ov[k]), 64'd0);
      check($sformatf("arst_data_%0d", k), od[k], 64'd0);
      check($sformatf("arst_busy_%0d", k), 64'(bz[k]), 64'd0);
      check($sformatf("arst_in_ready_%0d", k), 64'(ir[k]), 64'd1);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Random-ready soak across all depths and both rounding modes
    for (int n = 0; n < 800; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_data   = rand_vec();
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) tick();
    for (int k = 0; k < NI; k++) begin
      pend = 0;
      foreach (sbq[j]) if (sbq[j].inst == 3'(k)) pend++;
      check($sformatf("soak_pending_%0d", k), 64'(pend), 64'd0);
      check($sformatf("soak_idle_%0d", k), 64'(ov[k]), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
